exec_unit_mc: RTL
=================

# exec_unit_mc

Parametrised, multi-cycle execute stage for the venus pipeline. It sits between decode/operand-fetch and write-back. Single-cycle ALU operations (add/sub/shift/abs) complete in one cycle. Multiply, divide and remainder run on an iterative one-bit-per-cycle datapath. Upstream and downstream are coupled through a valid/stall handshake, and the unit keeps a committed C/Z/S/V flag register.

## Interface
Parameters:
- W_OPR, 32, operand/result width; power of two, ≥ 8
- ADDR, 32, PC width
- W_RD, 5, destination register index width
- W_OPC, 4, opcode width (fixed encoding below)
- W_CNT, $clog2(W_OPR), iteration counter and shift-amount width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- v_i  in  1  upstream instruction valid
- stall_o  out  1  unit cannot accept; upstream must hold all inputs stable
- opecode_i  in  W_OPC  operation
- opr0_i, opr1_i  in  W_OPR  operands
- wb_r_i  in  W_RD  destination register
- wb_i  in  1  instruction writes back
- pc_i  in  ADDR  instruction PC
- v_o  out  1  output register holds a valid result
- stall_i  in  1  downstream cannot accept; output register must hold
- result_o  out  W_OPR  result
- wb_r_o  out  W_RD  destination register, passed through
- wb_o  out  1  write-back enable; forced to 0 for reserved opcodes
- pc_o  out  ADDR  PC, passed through
- flags_o  out  4  committed flags {C,Z,S,V}
- busy_o  out  1  iterative operation in progress

## Operation
- Opcodes:
  - 0 ADD
  - 1 SUB (opr0−opr1)
  - 2 SHL
  - 3 SHR logical
  - 4 SAR arithmetic
  - 5 ABS(opr0)
  - 6 MUL (low W_OPR bits, unsigned)
  - 7 DIV (unsigned quotient)
  - 8 REM (unsigned remainder)
  - 9–15 reserved: result 0, wb_o 0, flags unchanged
- Shift amount is opr1_i[W_CNT-1:0]. ABS of the most negative value returns that value and sets V=1.
- Accept condition: v_i & ~stall_o.
- stall_o = (state != IDLE) | (v_o & stall_i).
- FSM states:
  - IDLE: an accepted single-cycle op loads the output register at the next edge. An accepted op 6–8 latches the operands, wb_r, wb, pc and op; clears the accumulator/partial remainder; sets cnt = W_OPR−1; goes to BUSY.
  - BUSY: one shift-add (MUL) or restoring-subtract (DIV/REM) step per cycle; cnt decrements. At cnt = 0 the last step is taken and the FSM goes to DONE.
  - DONE: if ~(v_o & stall_i), load the output register and go to IDLE. Otherwise hold.
- Output register: loads only when ~(v_o & stall_i). v_o clears when the held result is consumed (v_o & ~stall_i) and nothing new is loaded.
- Divide by zero: quotient = all ones, remainder = opr0, V=1.
- Flags update only when the output register loads:
  - Z = (result == 0)
  - S = result[W_OPR-1]
  - ADD: C = carry out; V = signed overflow
  - SUB: C = borrow; V = signed overflow
  - All other ops: C = 0; V = 0 except the ABS and divide-by-zero cases above.
- busy_o = (state == BUSY) | (state == DONE).

## Timing
- Reset values: v_o=0, result_o=0, wb_r_o=0, wb_o=0, pc_o=0, flags_o=0, state=IDLE, cnt=0. Hence stall_o=0 and busy_o=0.
- Reset mid-operation aborts the iterative op with no output.
- Single-cycle op latency: accepted at edge N, v_o=1 after edge N+1.
- MUL/DIV/REM latency: accepted at edge N; BUSY for W_OPR cycles; DONE for 1 cycle; v_o=1 after edge N+W_OPR+1 when downstream is not stalled.
- Throughput: 1 op/cycle for single-cycle ops with stall_i=0. No new op is accepted while BUSY or DONE.
- Back-to-back: when the output is consumed at the same edge a new result loads, v_o stays 1 and the new value appears with no bubble.
- stall_i asserted: result_o, wb_r_o, wb_o, pc_o and flags_o are held bit-stable.
- stall_o is combinational from state, v_o and stall_i. No combinational path exists from v_i to stall_o.

## Test plan
All scenarios use W_OPR=32.
- Reset during BUSY (MUL 7×9 at cycle 10 of 32): reset=1 for 1 cycle → next cycle v_o=0, busy_o=0, stall_o=0, flags_o=0, and no result ever emerges.
- Streamed ADD 0x7FFFFFFF+1 then SUB 0−1, stall_i=0:
  - First result 0x80000000, flags {0,0,1,1}.
  - Next cycle 0xFFFFFFFF, flags {1,0,1,0}.
  - stall_o=0 throughout.
- MUL 0x10000×0x10001: v_o rises exactly 33 cycles after acceptance; result 0x00010000; stall_o=1 for those 33 cycles.
- DIV 100/7 then REM 100/7 → 14, then 2. DIV 5/0 → 0xFFFFFFFF with V=1. REM 5/0 → 5.
- stall_i held high for 5 cycles while holding an ADD result, with a pending DIV in DONE:
  - Outputs stay stable and stall_o=1 throughout.
  - On release, ADD is consumed and the DIV result loads at the same edge (no bubble).
- Shifts: SAR 0x80000000 by 31 → 0xFFFFFFFF; SHR same → 1; SHL 1 by 35 → 8 (amount masked); opcode 12 → wb_o=0, result 0, flags unchanged.

Source files
------------

// File: rtl/exec_unit_mc_if.sv
// Execute-stage handshake bundle: upstream issue port, downstream result port and status.
// The master side is the pipeline around the unit; the slave side is the unit itself.
interface exec_unit_mc_if #(
  parameter int unsigned W_OPR = 32,
  parameter int unsigned ADDR  = 32,
  parameter int unsigned W_RD  = 5,
  parameter int unsigned W_OPC = 4
);
  logic             v_i;
  logic             stall_o;
  logic [W_OPC-1:0] opecode_i;
  logic [W_OPR-1:0] opr0_i;
  logic [W_OPR-1:0] opr1_i;
  logic [W_RD-1:0]  wb_r_i;
  logic             wb_i;
  logic [ADDR-1:0]  pc_i;
  logic             v_o;
  logic             stall_i;
  logic [W_OPR-1:0] result_o;
  logic [W_RD-1:0]  wb_r_o;
  logic             wb_o;
  logic [ADDR-1:0]  pc_o;
  logic [3:0]       flags_o;
  logic             busy_o;

  modport master (
    output v_i, opecode_i, opr0_i, opr1_i, wb_r_i, wb_i, pc_i, stall_i,
    input  stall_o, v_o, result_o, wb_r_o, wb_o, pc_o, flags_o, busy_o
  );

  modport slave (
    input  v_i, opecode_i, opr0_i, opr1_i, wb_r_i, wb_i, pc_i, stall_i,
    output stall_o, v_o, result_o, wb_r_o, wb_o, pc_o, flags_o, busy_o
  );
endinterface

// File: rtl/exec_unit_mc.sv
// Multi-cycle execute stage: single-cycle ALU ops pass through an issue register, MUL/DIV/REM
// iterate one bit per cycle; results land in a stallable output register with C/Z/S/V flags.
module exec_unit_mc #(
  parameter int unsigned W_OPR = 32,
  parameter int unsigned ADDR  = 32,
  parameter int unsigned W_RD  = 5,
  parameter int unsigned W_OPC = 4,
  parameter int unsigned W_CNT = $clog2(W_OPR)
) (
  input logic           clk,
  input logic           reset,
  exec_unit_mc_if.slave bus
);
  localparam logic [W_OPC-1:0] OpAdd = W_OPC'(0);
  localparam logic [W_OPC-1:0] OpSub = W_OPC'(1);
  localparam logic [W_OPC-1:0] OpShl = W_OPC'(2);
  localparam logic [W_OPC-1:0] OpShr = W_OPC'(3);
  localparam logic [W_OPC-1:0] OpSar = W_OPC'(4);
  localparam logic [W_OPC-1:0] OpAbs = W_OPC'(5);
  localparam logic [W_OPC-1:0] OpMul = W_OPC'(6);
  localparam logic [W_OPC-1:0] OpDiv = W_OPC'(7);
  localparam logic [W_OPC-1:0] OpRem = W_OPC'(8);
  localparam logic [W_OPR-1:0] MinNeg = {1'b1, {(W_OPR-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [W_CNT-1:0] cnt_q, cnt_d;
  logic             s1_v_q, s1_v_d;
  logic [W_OPC-1:0] iss_op_q, iss_op_d;
  logic [W_OPR-1:0] iss_a_q, iss_a_d;
  logic [W_OPR-1:0] iss_b_q, iss_b_d;
  logic [W_RD-1:0]  iss_rd_q, iss_rd_d;
  logic             iss_wb_q, iss_wb_d;
  logic [ADDR-1:0]  iss_pc_q, iss_pc_d;
  logic [W_OPR-1:0] acc_q, acc_d;
  logic [W_OPR-1:0] rem_q, rem_d;
  logic             v_o_q, v_o_d;
  logic [W_OPR-1:0] res_q, res_d;
  logic [W_RD-1:0]  rd_o_q, rd_o_d;
  logic             wb_o_q, wb_o_d;
  logic [ADDR-1:0]  pc_o_q, pc_o_d;
  logic [3:0]       flags_q, flags_d;

  logic out_hold, accept, in_iter, out_load;

  assign out_hold    = v_o_q & bus.stall_i;
  assign bus.stall_o = (state_q != StIdle) | out_hold;
  assign accept      = bus.v_i & ~bus.stall_o;
  assign in_iter     = bus.opecode_i inside {OpMul, OpDiv, OpRem};
  assign out_load    = ~out_hold & (s1_v_q | (state_q == StDone));

  // Single-cycle ALU, evaluated on the issue register.
  logic [W_OPR:0]   sum, diff;
  logic [W_CNT-1:0] shamt;
  logic [W_OPR-1:0] alu_res;
  logic             alu_c, alu_v, alu_rsv;

  always_comb begin
    sum     = {1'b0, iss_a_q} + {1'b0, iss_b_q};
    diff    = {1'b0, iss_a_q} - {1'b0, iss_b_q};
    shamt   = iss_b_q[W_CNT-1:0];
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_rsv = 1'b0;
    case (iss_op_q)
      OpAdd: begin
        alu_res = sum[W_OPR-1:0];
        alu_c   = sum[W_OPR];
        alu_v   = (iss_a_q[W_OPR-1] == iss_b_q[W_OPR-1]) &
                  (alu_res[W_OPR-1] != iss_a_q[W_OPR-1]);
      end
      OpSub: begin
        alu_res = diff[W_OPR-1:0];
        alu_c   = diff[W_OPR];
        alu_v   = (iss_a_q[W_OPR-1] != iss_b_q[W_OPR-1]) &
                  (alu_res[W_OPR-1] != iss_a_q[W_OPR-1]);
      end
      OpShl: alu_res = iss_a_q << shamt;
      OpShr: alu_res = iss_a_q >> shamt;
      OpSar: alu_res = $unsigned($signed(iss_a_q) >>> shamt);
      OpAbs: begin
        alu_res = iss_a_q[W_OPR-1] ? (~iss_a_q + W_OPR'(1)) : iss_a_q;
        alu_v   = (iss_a_q == MinNeg);
      end
      default: alu_rsv = 1'b1;
    endcase
  end

  // One MSB-first iteration: shift-add for MUL, restoring subtract for DIV/REM.
  logic [W_OPR:0]   rem_sh;
  logic [W_OPR-1:0] rem_sub;
  logic [W_OPR-1:0] mul_acc;
  logic             div_ge;

  always_comb begin
    rem_sh  = {rem_q, iss_a_q[cnt_q]};
    div_ge  = rem_sh >= {1'b0, iss_b_q};
    rem_sub = rem_sh[W_OPR-1:0] - iss_b_q;
    mul_acc = {acc_q[W_OPR-2:0], 1'b0} + (iss_b_q[cnt_q] ? iss_a_q : '0);
  end

  logic [W_OPR-1:0] ld_res;
  logic             ld_c, ld_v, ld_rsv;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    s1_v_d   = s1_v_q;
    iss_op_d = iss_op_q;
    iss_a_d  = iss_a_q;
    iss_b_d  = iss_b_q;
    iss_rd_d = iss_rd_q;
    iss_wb_d = iss_wb_q;
    iss_pc_d = iss_pc_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    v_o_d    = v_o_q;
    res_d    = res_q;
    rd_o_d   = rd_o_q;
    wb_o_d   = wb_o_q;
    pc_o_d   = pc_o_q;
    flags_d  = flags_q;

    if (accept) begin
      iss_op_d = bus.opecode_i;
      iss_a_d  = bus.opr0_i;
      iss_b_d  = bus.opr1_i;
      iss_rd_d = bus.wb_r_i;
      iss_wb_d = bus.wb_i;
      iss_pc_d = bus.pc_i;
    end
    // The issue register drains every cycle the output is free; it is empty outside StIdle.
    if (!out_hold) s1_v_d = accept & ~in_iter;

    case (state_q)
      StIdle: begin
        if (accept && in_iter) begin
          state_d = StBusy;
          cnt_d   = W_CNT'(W_OPR - 1);
          acc_d   = '0;
          rem_d   = '0;
        end
      end
      StBusy: begin
        if (iss_op_q == OpMul) begin
          acc_d = mul_acc;
        end else begin
          acc_d = {acc_q[W_OPR-2:0], div_ge};
          rem_d = div_ge ? rem_sub : rem_sh[W_OPR-1:0];
        end
        cnt_d = cnt_q - W_CNT'(1);
        if (cnt_q == '0) state_d = StDone;
      end
      StDone: begin
        if (!out_hold) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_q == StDone) begin
      ld_res = (iss_op_q == OpRem) ? rem_q : acc_q;
      ld_c   = 1'b0;
      ld_v   = (iss_op_q != OpMul) & (iss_b_q == '0);
      ld_rsv = 1'b0;
    end else begin
      ld_res = alu_res;
      ld_c   = alu_c;
      ld_v   = alu_v;
      ld_rsv = alu_rsv;
    end

    if (out_load) begin
      v_o_d  = 1'b1;
      res_d  = ld_res;
      rd_o_d = iss_rd_q;
      wb_o_d = iss_wb_q & ~ld_rsv;
      pc_o_d = iss_pc_q;
      if (!ld_rsv) flags_d = {ld_c, ld_res == '0, ld_res[W_OPR-1], ld_v};
    end else if (v_o_q && !bus.stall_i) begin
      v_o_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      s1_v_q   <= 1'b0;
      iss_op_q <= '0;
      iss_a_q  <= '0;
      iss_b_q  <= '0;
      iss_rd_q <= '0;
      iss_wb_q <= 1'b0;
      iss_pc_q <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      v_o_q    <= 1'b0;
      res_q    <= '0;
      rd_o_q   <= '0;
      wb_o_q   <= 1'b0;
      pc_o_q   <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s1_v_q   <= s1_v_d;
      iss_op_q <= iss_op_d;
      iss_a_q  <= iss_a_d;
      iss_b_q  <= iss_b_d;
      iss_rd_q <= iss_rd_d;
      iss_wb_q <= iss_wb_d;
      iss_pc_q <= iss_pc_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      v_o_q    <= v_o_d;
      res_q    <= res_d;
      rd_o_q   <= rd_o_d;
      wb_o_q   <= wb_o_d;
      pc_o_q   <= pc_o_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.v_o      = v_o_q;
  assign bus.result_o = res_q;
  assign bus.wb_r_o   = rd_o_q;
  assign bus.wb_o     = wb_o_q;
  assign bus.pc_o     = pc_o_q;
  assign bus.flags_o  = flags_q;
  assign bus.busy_o   = (state_q == StBusy) | (state_q == StDone);
endmodule
